// File: rtl/go_jump_seq_pkg.sv
// Shared types and default parameters for the go/jump ring sequencer.
package go_jump_seq_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'd0,
    CMD_STEP = 2'd1,
    CMD_JUMP = 2'd2
  } cmd_e;

  localparam int         DEF_NUM_STATES = 8;
  localparam int         DEF_JUMP_STEP  = 2;
  localparam logic [7:0] DEF_Y_MASK     = 8'h18;
  localparam int         DEF_CNT_W      = 8;

endpackage

// File: rtl/go_jump_modadd.sv
// Combinational ring adder: (state + increment) mod NUM_STATES plus wrap flag.
module go_jump_modadd #(
  parameter int NUM_STATES = 8,
  parameter int STATE_W    = 3
) (
  input  logic [STATE_W-1:0] state,
  input  logic [STATE_W-1:0] increment,
  output logic [STATE_W-1:0] next_state,
  output logic               wrap
);

  localparam logic [STATE_W:0] MODULUS = (STATE_W+1)'(NUM_STATES);

  logic [STATE_W:0] sum;

  // One extra bit holds the unreduced sum; a single subtract reduces it since both operands < NUM_STATES.
  always_comb begin
    sum        = {1'b0, state} + {1'b0, increment};
    wrap       = (sum >= MODULUS);
    next_state = wrap ? STATE_W'(sum - MODULUS) : sum[STATE_W-1:0];
  end

endmodule

// File: rtl/go_jump_seq.sv
// Ring sequencer advanced by go (one step) or jump (JUMP_STEP steps, priority).
// Optional saturating step counter enabled by macro GO_JUMP_SEQ_CNT_EN.
//
// state                 | meaning
// 0 .. NUM_STATES-1     | ring position; y = Y_MASK[state]
module go_jump_seq
  import go_jump_seq_pkg::*;
#(
  parameter int                    NUM_STATES = DEF_NUM_STATES,
  parameter int                    STATE_W    = 3,
  parameter int                    JUMP_STEP  = DEF_JUMP_STEP,
  parameter logic [NUM_STATES-1:0] Y_MASK     = DEF_Y_MASK,
  parameter int                    CNT_W      = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               jump,
  output logic               y,
  output logic [STATE_W-1:0] state,
  output logic               wrap,
  output logic [CNT_W-1:0]   step_cnt
);

  if (NUM_STATES < 2 || NUM_STATES > (2 ** STATE_W)) begin : g_bad_num_states
    $error("go_jump_seq: NUM_STATES=%0d outside 2..2**STATE_W", NUM_STATES);
  end
  if (JUMP_STEP < 1 || JUMP_STEP > NUM_STATES - 1) begin : g_bad_jump_step
    $error("go_jump_seq: JUMP_STEP=%0d outside 1..NUM_STATES-1", JUMP_STEP);
  end

  cmd_e               cmd;
  logic [STATE_W-1:0] increment;
  logic [STATE_W-1:0] state_next;
  logic               wrap_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      wrap  <= wrap_next;
    end
  end

  always_comb begin
    cmd = CMD_HOLD;
    if (jump)    cmd = CMD_JUMP;
    else if (go) cmd = CMD_STEP;
  end

  // A hold adds zero, so the adder never reports wrap for it.
  always_comb begin
    unique case (cmd)
      CMD_JUMP: increment = STATE_W'(JUMP_STEP);
      CMD_STEP: increment = STATE_W'(1);
      default:  increment = '0;
    endcase
  end

  go_jump_modadd #(
    .NUM_STATES (NUM_STATES),
    .STATE_W    (STATE_W)
  ) u_modadd (
    .state      (state),
    .increment  (increment),
    .next_state (state_next),
    .wrap       (wrap_next)
  );

  always_comb begin
    y = Y_MASK[state];
  end

`ifdef GO_JUMP_SEQ_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cmd != CMD_HOLD && cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign step_cnt = cnt;
`else
  assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_go_jump_seq.sv
// Self-checking bench for go_jump_seq: directed scenarios plus random traffic
// against a behavioural ring model.
module tb_go_jump_seq;

  localparam int N       = 8;
  localparam int STEP    = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             go = 1'b0;
  logic             jump = 1'b0;
  logic             y;
  logic [2:0]       state;
  logic             wrap;
  logic [CNT_W-1:0] step_cnt;

  int checks = 0;
  int errors = 0;

  int   m_state = 0;
  int   m_wrap  = 0;
  int   m_cnt   = 0;
  logic [7:0] ymask = 8'h18;

  go_jump_seq dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .jump     (jump),
    .y        (y),
    .state    (state),
    .wrap     (wrap),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt();
`ifdef GO_JUMP_SEQ_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  // One clock edge: drive request, advance model, compare all outputs.
  task automatic tick(input string tag, input logic r, input logic g, input logic j);
    int sum;
    reset = r;
    go    = g;
    jump  = j;
    @(posedge clk);
    #1;
    if (r) begin
      m_state = 0;
      m_wrap  = 0;
      m_cnt   = 0;
    end else if (g || j) begin
      sum     = m_state + (j ? STEP : 1);
      m_wrap  = (sum >= N) ? 1 : 0;
      m_state = sum % N;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_wrap = 0;
    end
    check({tag, "_state"}, 32'(state), 32'(m_state));
    check({tag, "_y"}, 32'(y), 32'(ymask[m_state]));
    check({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
    check({tag, "_cnt"}, 32'(step_cnt), 32'(exp_cnt()));
  endtask

  initial begin
    int r;
    int g;
    int j;

    // Reset held with go asserted
    repeat (3) tick("reset", 1'b1, 1'b1, 1'b0);
    check("reset_const_state", 32'(state), 0);
    check("reset_const_y", 32'(y), 0);

    // Single steps
    tick("go1", 1'b0, 1'b1, 1'b0);
    tick("go2", 1'b0, 1'b1, 1'b0);
    tick("go3", 1'b0, 1'b1, 1'b0);
    check("go3_const_y", 32'(y), 1);
    tick("go4", 1'b0, 1'b1, 1'b0);
    check("go4_const_state", 32'(state), 4);

    // Jump priority from state 3
    tick("rst2", 1'b1, 1'b0, 1'b0);
    repeat (3) tick("to3", 1'b0, 1'b1, 1'b0);
    tick("jump35", 1'b0, 1'b0, 1'b1);
    check("jump35_const", 32'(state), 5);
    tick("both57", 1'b0, 1'b1, 1'b1);
    check("both57_const", 32'(state), 7);

    // Wrap-around cases
    tick("wrap_go70", 1'b0, 1'b1, 1'b0);
    check("wrap_go70_const", 32'(wrap), 1);
    tick("hold0", 1'b0, 1'b0, 1'b0);
    check("hold0_const_wrap", 32'(wrap), 0);
    repeat (3) tick("to6", 1'b0, 1'b0, 1'b1);
    tick("wrap_j60", 1'b0, 1'b0, 1'b1);
    check("wrap_j60_const", 32'(wrap), 1);
    repeat (7) tick("to7", 1'b0, 1'b1, 1'b0);
    tick("wrap_j71", 1'b0, 1'b0, 1'b1);
    check("wrap_j71_const_state", 32'(state), 1);
    tick("hold1", 1'b0, 1'b0, 1'b0);

    // Mid-operation reset at state 5
    repeat (2) tick("to5", 1'b0, 1'b0, 1'b1);
    tick("midrst", 1'b1, 1'b1, 1'b0);
    check("midrst_const_cnt", 32'(step_cnt), 0);
    tick("after_rst", 1'b0, 1'b1, 1'b0);
    check("after_rst_const", 32'(state), 1);

    // Counter saturation
    tick("rst3", 1'b1, 1'b0, 1'b0);
    repeat (300) tick("sat", 1'b0, 1'b1, 1'b0);
    check("sat_const_state", 32'(state), 4);
`ifdef GO_JUMP_SEQ_CNT_EN
    check("sat_const_cnt", 32'(step_cnt), 255);
`else
    check("sat_const_cnt", 32'(step_cnt), 0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 31) == 0) ? 1 : 0;
      g = $urandom_range(0, 1);
      j = ($urandom_range(0, 3) == 0) ? 1 : 0;
      tick("rand", r[0], g[0], j[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/go_jump_seq.md
GO_JUMP_SEQ -- requirements
Module: go_jump_seq

Interface
REQ-001 The module SHALL have parameter NUM_STATES, default 8: number of ring states, legal range 2..2**STATE_W.
REQ-002 The module SHALL have parameter STATE_W, default 3: state index width.
REQ-003 The module SHALL have parameter JUMP_STEP, default 2: states advanced per jump, legal range 1..NUM_STATES-1.
REQ-004 The module SHALL have parameter Y_MASK, default 8'h18, width NUM_STATES: bit i set means y asserted in state i.
REQ-005 The module SHALL have parameter CNT_W, default 8: step counter width.
REQ-006 The module SHALL have port clk, input, 1 bit: single clock, all state changes on rising edge.
REQ-007 The module SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-008 The module SHALL have port go, input, 1 bit: single-step advance request.
REQ-009 The module SHALL have port jump, input, 1 bit: multi-step advance request.
REQ-010 The module SHALL have port y, output, 1 bit: Moore output, Y_MASK[state].
REQ-011 The module SHALL have port state, output, STATE_W bits: current state index.
REQ-012 The module SHALL have port wrap, output, 1 bit: one-cycle pulse on ring wrap-around.
REQ-013 The module SHALL have port step_cnt, output, CNT_W bits: count of transitions taken.

Function
REQ-014 go and jump SHALL be sampled on every rising clk edge while reset=0.
REQ-015 With go=0 and jump=0, state SHALL hold.
REQ-016 With go=1 and jump=0, the next state SHALL be (state+1) mod NUM_STATES.
REQ-017 With jump=1, the next state SHALL be (state+JUMP_STEP) mod NUM_STATES, regardless of go; jump has priority.
REQ-018 The modulo add SHALL be computed STATE_W+1 bits wide, subtracting NUM_STATES when the sum is >= NUM_STATES; no division or multiplication.
REQ-019 The state register SHALL never hold a value >= NUM_STATES.
REQ-020 y SHALL equal Y_MASK[state], decoded from the state register only (no input-to-output path).
REQ-021 y SHALL change in the same cycle as state, one edge after the request.
REQ-022 wrap SHALL be a registered pulse of exactly 1 for the cycle following any transition whose unreduced sum is >= NUM_STATES, and 0 otherwise.
REQ-023 Holds SHALL never assert wrap.
REQ-024 step_cnt SHALL increment by 1 on each go or jump transition.
REQ-025 step_cnt SHALL saturate at 2**CNT_W-1 and SHALL NOT wrap.

Reset
REQ-026 With reset=1 at a rising edge: state=0, wrap=0, step_cnt=0; y therefore equals Y_MASK[0].
REQ-027 reset SHALL override go and jump at any point mid-operation.
REQ-028 The first transition after reset deasserts SHALL occur at the first edge with reset=0 and a request present.

Configuration
REQ-029 Macro GO_JUMP_SEQ_CNT_EN defined: the step_cnt register and saturating logic SHALL be implemented per REQ-024/025.
REQ-030 Macro GO_JUMP_SEQ_CNT_EN undefined: no counter register SHALL exist; step_cnt SHALL be tied to 0; all other behaviour unchanged.

Structure
REQ-031 Shared package go_jump_seq_pkg SHALL hold:
- command enum CMD_HOLD/CMD_STEP/CMD_JUMP
- default parameter constants: NUM_STATES, JUMP_STEP, Y_MASK, CNT_W
REQ-032 A single combinational sub-module go_jump_modadd SHALL compute the next state and wrap flag.
- Inputs: state, increment.
- Parameters: NUM_STATES, STATE_W.
REQ-033 The top level SHALL contain only the command decode, registers and counter.
REQ-034 An elaboration-time check SHALL flag NUM_STATES or JUMP_STEP outside the legal ranges.

Verification (defaults N=8, STEP=2, Y_MASK=8'h18)
REQ-035 Reset: hold reset=1 for 3 cycles with go=1 -> state=0, y=0, wrap=0, step_cnt=0 throughout.
REQ-036 Single steps: go=1 for 3 edges from state 0 -> state 1,2,3; y=1 at state 3; go=1 once more -> state 4, y=1.
REQ-037 Jump priority: at state 3 jump=1 -> state 5, y=0; go=1 and jump=1 together at state 5 -> state 7.
REQ-038 Wrap-around:
- state 7, go -> 0 with wrap=1 for one cycle
- state 6, jump -> 0 with wrap=1
- state 7, jump -> 1 with wrap=1
- hold -> wrap=0
REQ-039 Mid-operation reset: at state 5 with go=1, reset=1 for one edge -> state=0, step_cnt=0; the next edge with go=1 -> state 1.
REQ-040 Counter saturation: 300 consecutive go edges.
- GO_JUMP_SEQ_CNT_EN defined -> step_cnt=255.
- GO_JUMP_SEQ_CNT_EN undefined -> step_cnt=0.
- In both builds, final state = 300 mod 8 = 4.
